vec_mem_seq: RTL and testbench
==============================

Name: vec_mem_seq

Overview:
- Parametrised vector load/store sequencer; next generation of the processor's hard-coded 16x16-bit Load/Store states.
- Moves up to LANES elements of ELEM_W bits between the memory port and a flat vector bus.
- Adds signed stride, per-lane mask, element count and a memory-ready stall.
- Sits between the core's execute stage and the data memory interface.

Parameters:
- LANES, 16, number of vector elements
- ELEM_W, 16, element width in bits; equals memory word width
- ADDR_W, 16, memory address width
- CNT_W, $clog2(LANES+1), width of the count field

Ports:
- Clk1  in  1  clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load; latched at start
- base_addr  in  ADDR_W  address of lane 0
- stride  in  ADDR_W  signed two's-complement address step per lane
- count  in  CNT_W  lanes to process; values above LANES clamp to LANES
- mask  in  LANES  per-lane enable; bit i is lane i
- store_vec  in  LANES*ELEM_W  store data; lane i is bits [i*ELEM_W +: ELEM_W]; latched at start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- load_vec  out  LANES*ELEM_W  loaded vector; same lane packing as store_vec
- Addr  out  ADDR_W  memory address
- RD  out  1  read request
- WR  out  1  write request
- dataOut  out  ELEM_W  write data
- DataIn  in  ELEM_W  read data, valid exactly 1 cycle after an accepted RD
- mem_ready  in  1  memory accepts RD/WR in this cycle

Behaviour:
- Reset values: busy=0, done=0, RD=0, WR=0, Addr=0, dataOut=0, load_vec=0, state=IDLE.
- Reset mid-operation aborts immediately; no further RD/WR is issued. A read already in flight is discarded.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches is_store, base_addr, stride, clamp(count), mask and store_vec, and clears load_vec to 0.
  - If clamped count=0, next state is DONE. Otherwise, next state is ISSUE with lane index i=0 and address accumulator a=base_addr.
- ISSUE (lane i, address a):
  - mask[i]=0: no access; RD=WR=0; lane is skipped. For a load, load_vec lane i stays 0. The skip consumes one cycle; then i++ and a+=stride.
  - mask[i]=1: drive Addr=a. Drive RD=1 (load) or WR=1 with dataOut=lane i (store). Requests are Moore outputs of the registered i/a.
  - Access is accepted in a cycle where RD|WR and mem_ready are both 1. On acceptance, i++ and a+=stride. If mem_ready=0, hold Addr, RD/WR and dataOut unchanged (stall).
  - After lane count-1 is accepted or skipped, go to DRAIN.
- Load capture: accepted read for lane j in cycle k; DataIn is written to load_vec lane j at the end of cycle k+1. Reads are pipelined, one accepted per cycle.
- DRAIN: one cycle with RD=WR=0; captures the last read's data. Next state is DONE. DRAIN is also entered for stores, giving uniform latency.
- DONE: done=1 for exactly one cycle; load_vec is final. Next state is IDLE.
- load_vec holds its value until the next accepted start.
- Latency with count=N, no stalls: start sampled in cycle 0, ISSUE cycles 1..N, DRAIN cycle N+1, done in cycle N+2.
- Address arithmetic: a+=stride is modulo 2^ADDR_W. Wrap-around and negative strides are legal; no error is flagged.
- start while busy is ignored, with no queueing.
- start and Reset in the same cycle: Reset wins.
- Lanes i >= count are never accessed, and their load_vec lanes read 0.

Decomposition:
- Shared package vec_pkg holds:
  - state enum (IDLE, ISSUE, DRAIN, DONE)
  - lane slice helper function, lane i of a flat vector
  - default LANES/ELEM_W/ADDR_W constants reused by the register files and ALU
- One natural sub-module: vec_lane_addr_gen. It owns the i/a counters, mask skip and count compare, and outputs the current lane, address and last flag.

Test Plan:
- Load, base=0x0100, stride=1, count=16, mask=0xFFFF, mem_ready=1, memory[0x100+i]=i*3 -> RD addresses 0x100..0x10F in cycles 1..16; done in cycle 18; load_vec lane i = i*3.
- Store, base=0x0200, stride=-2 (0xFFFE), count=4, store_vec lanes 0xA0..0xA3 -> WR at 0x200, 0x1FE, 0x1FC, 0x1FA with dataOut 0xA0..0xA3; done in cycle 6.
- Load, count=8, mask=0x00A5 -> RD only for lanes 0, 2, 5, 7; load_vec lanes 1, 3, 4, 6 and 8..15 read 0; done in cycle 10.
- Stall: load of count=3; mem_ready=0 for 2 cycles during lane 1 -> Addr/RD held constant; lane 1 data is captured the cycle after acceptance; done is 2 cycles later than the unstalled case (cycle 7).
- Boundaries: base=0xFFFF, stride=1, count=2 -> addresses 0xFFFF, 0x0000. count=0 -> no RD/WR; done in cycle 1. count=20 -> clamps to 16 lanes.
- Reset asserted during ISSUE lane 5 -> next cycle RD=WR=0, busy=0, load_vec=0. start pulsed while busy -> ignored; the first operation's done timing is unchanged.

Source files
------------

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and defaults for the vector load/store sequencer
package vec_pkg;

  localparam int DEF_LANES  = 16;
  localparam int DEF_ELEM_W = 16;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // Lane idx of a flat vector at the default geometry.
  function automatic logic [DEF_ELEM_W-1:0] lane_of(
    input logic [DEF_LANES*DEF_ELEM_W-1:0] vec,
    input int unsigned                     idx
  );
    return vec[idx*DEF_ELEM_W +: DEF_ELEM_W];
  endfunction

endpackage

// File: rtl/vec_lane_addr_gen.sv
// rtl/vec_lane_addr_gen.sv - lane index / strided address walker with mask and count
module vec_lane_addr_gen #(
  parameter int LANES  = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 5,
  parameter int LW     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [LANES-1:0]  mask_i,
  output logic [LW-1:0]     lane_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              lane_en_o,
  output logic              last_o
);

  logic [LW-1:0]     lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q;
  logic [CNT_W-1:0]  count_q;
  logic [LANES-1:0]  mask_q;

  // Address wraps modulo 2^ADDR_W; a negative stride is just a large unsigned add.
  always_comb begin
    lane_d = lane_q;
    addr_d = addr_q;
    if (load_i) begin
      lane_d = '0;
      addr_d = base_i;
    end else if (advance_i) begin
      lane_d = lane_q + LW'(1);
      addr_d = addr_q + stride_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q   <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      count_q  <= '0;
      mask_q   <= '0;
    end else begin
      lane_q <= lane_d;
      addr_q <= addr_d;
      if (load_i) begin
        stride_q <= stride_i;
        count_q  <= count_i;
        mask_q   <= mask_i;
      end
    end
  end

  assign lane_o    = lane_q;
  assign addr_o    = addr_q;
  assign lane_en_o = mask_q[lane_q];
  assign last_o    = (CNT_W'(lane_q) + CNT_W'(1)) == count_q;

endmodule

// File: rtl/vec_mem_seq.sv
// rtl/vec_mem_seq.sv - vector load/store sequencer between execute stage and data memory
module vec_mem_seq
  import vec_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = $clog2(LANES + 1)
) (
  input  logic                    Clk1,
  input  logic                    Reset,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [CNT_W-1:0]        count,
  input  logic [LANES-1:0]        mask,
  input  logic [LANES*ELEM_W-1:0] store_vec,
  output logic                    busy,
  output logic                    done,
  output logic [LANES*ELEM_W-1:0] load_vec,
  output logic [ADDR_W-1:0]       Addr,
  output logic                    RD,
  output logic                    WR,
  output logic [ELEM_W-1:0]       dataOut,
  input  logic [ELEM_W-1:0]       DataIn,
  input  logic                    mem_ready
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                  state_q;
  logic                    store_q;
  logic [LANES*ELEM_W-1:0] sdata_q;
  logic [LANES*ELEM_W-1:0] load_vec_q;
  logic                    rd_pend_q;
  logic [LW-1:0]           rd_lane_q;

  logic [CNT_W-1:0]  cnt_clamped;
  logic              accept_start, in_issue, access, advance;
  logic [LW-1:0]     lane;
  logic [ADDR_W-1:0] lane_addr;
  logic              lane_en, last;

  assign cnt_clamped  = (count > CNT_W'(LANES)) ? CNT_W'(LANES) : count;
  assign accept_start = (state_q == IDLE) && start;
  assign in_issue     = (state_q == ISSUE);
  assign access       = in_issue && lane_en;
  // A masked-off lane always advances; an enabled lane waits for the memory.
  assign advance      = in_issue && (!lane_en || mem_ready);

  vec_lane_addr_gen #(
    .LANES (LANES),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W),
    .LW    (LW)
  ) u_addr_gen (
    .clk_i    (Clk1),
    .rst_i    (Reset),
    .load_i   (accept_start),
    .advance_i(advance),
    .base_i   (base_addr),
    .stride_i (stride),
    .count_i  (cnt_clamped),
    .mask_i   (mask),
    .lane_o   (lane),
    .addr_o   (lane_addr),
    .lane_en_o(lane_en),
    .last_o   (last)
  );

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      sdata_q    <= '0;
      load_vec_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_lane_q  <= '0;
    end else begin
      // Read data arrives one cycle after acceptance; capture it into that lane.
      rd_pend_q <= RD && mem_ready;
      rd_lane_q <= lane;
      if (rd_pend_q) begin
        load_vec_q[rd_lane_q*ELEM_W +: ELEM_W] <= DataIn;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            store_q    <= is_store;
            sdata_q    <= store_vec;
            load_vec_q <= '0;
            state_q    <= (cnt_clamped == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (advance && last) state_q <= DRAIN;
        end
        DRAIN:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign load_vec = load_vec_q;
  assign RD       = access && !store_q;
  assign WR       = access && store_q;
  assign Addr     = access ? lane_addr : '0;
  assign dataOut  = WR ? sdata_q[lane*ELEM_W +: ELEM_W] : '0;

endmodule

// File: tb/tb_vec_mem_seq.sv
// tb/tb_vec_mem_seq.sv - randomized self-checking bench for vec_mem_seq
module tb_vec_mem_seq;
  import vec_pkg::*;

  logic         Clk1, Reset, start, is_store;
  logic [15:0]  base_addr, stride, mask;
  logic [4:0]   count;
  logic [255:0] store_vec, load_vec;
  logic         busy, done, RD, WR, mem_ready;
  logic [15:0]  Addr, dataOut, DataIn;

  vec_mem_seq dut (
    .Clk1(Clk1), .Reset(Reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .stride(stride), .count(count), .mask(mask),
    .store_vec(store_vec), .busy(busy), .done(done), .load_vec(load_vec),
    .Addr(Addr), .RD(RD), .WR(WR), .dataOut(dataOut), .DataIn(DataIn),
    .mem_ready(mem_ready)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:65535];
  bit          ready_plan [64];
  logic [15:0] snap_addr [64];
  bit          snap_rd [64];
  int          cyc;
  bit          pend;
  logic [15:0] pend_addr;
  int          done_cyc, done_cnt;
  bit          last_busy;

  int          acc_cyc[$], exp_cyc[$];
  logic [15:0] acc_addr[$], exp_addr[$], acc_data[$], exp_data[$];
  bit          acc_wr[$], exp_wr[$];
  logic [255:0] exp_vec;
  int          exp_done;

  bit           op_st;
  logic [15:0]  op_base, op_stride, op_mask;
  logic [4:0]   op_cnt;
  logic [255:0] op_svec;
  int           op_restart;

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock: feed read data of last cycle's accepted read, apply ready, log accesses.
  task automatic step();
    @(negedge Clk1);
    DataIn    = pend ? mem[pend_addr] : 16'($urandom);
    mem_ready = (cyc >= 0 && cyc < 64) ? ready_plan[cyc] : 1'b1;
    if (cyc >= 0 && cyc < 64) begin
      snap_addr[cyc] = Addr;
      snap_rd[cyc]   = RD;
    end
    pend = RD && mem_ready;
    if (pend) begin
      pend_addr = Addr;
      acc_cyc.push_back(cyc); acc_addr.push_back(Addr);
      acc_wr.push_back(1'b0); acc_data.push_back(16'h0);
    end
    if (WR && mem_ready) begin
      mem[Addr] = dataOut;
      acc_cyc.push_back(cyc); acc_addr.push_back(Addr);
      acc_wr.push_back(1'b1); acc_data.push_back(dataOut);
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    last_busy = busy;
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); acc_addr.delete(); acc_wr.delete(); acc_data.delete();
    done_cyc = -1; done_cnt = 0; pend = 1'b0;
  endtask

  task automatic run_op();
    clear_logs();
    cyc = 0;
    step();
    start = 1'b1; is_store = op_st; base_addr = op_base; stride = op_stride;
    count = op_cnt; mask = op_mask; store_vec = op_svec;
    cyc = 1;
    while (cyc <= 200) begin
      step();
      start = (cyc == op_restart);
      if (start) begin
        is_store = 1'($urandom); base_addr = 16'($urandom); stride = 16'($urandom);
        count = 5'($urandom_range(1, 16)); mask = 16'($urandom); store_vec = rand_vec();
      end
      if (done_cyc >= 0 && cyc > done_cyc) break;
      cyc++;
    end
    start = 1'b0;
  endtask

  // Reference: walk lanes in order, each enabled lane waits for a ready cycle.
  task automatic model_op();
    int n, c;
    logic [15:0] a;
    exp_cyc.delete(); exp_addr.delete(); exp_wr.delete(); exp_data.delete();
    exp_vec = '0;
    n = (op_cnt > 5'd16) ? 16 : int'(op_cnt);
    c = 1;
    a = op_base;
    for (int l = 0; l < n; l++) begin
      if (op_mask[l]) begin
        while (c < 64 && !ready_plan[c]) c++;
        exp_cyc.push_back(c); exp_addr.push_back(a); exp_wr.push_back(op_st);
        exp_data.push_back(op_st ? lane_of(op_svec, unsigned'(l)) : 16'h0);
        if (!op_st) exp_vec[l*16 +: 16] = mem[a];
      end
      c++;
      a = a + op_stride;
    end
    exp_done = (n == 0) ? 1 : c + 1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; cyc = -1;
    repeat (3) step();
    total++;
    if ({busy, done, RD, WR} !== 4'b0 || Addr !== 16'h0 || dataOut !== 16'h0 || load_vec !== '0) begin
      bad++;
      $display("FAIL reset_state busy=%b done=%b RD=%b WR=%b Addr=%h dataOut=%h lv_zero=%b required all zero",
               busy, done, RD, WR, Addr, dataOut, load_vec == '0);
    end
    start = 1'b1; count = 5'd4; mask = 16'hFFFF;
    step();
    Reset = 1'b0; start = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_beats_start busy=%b required 0", busy);
    end
  endtask

  task automatic test_transfers();
    for (int idx = 0; idx < 47; idx++) begin
      for (int k = 0; k < 64; k++) ready_plan[k] = 1'b1;
      op_restart = -1;
      op_svec = rand_vec();
      op_st = 1'b0; op_stride = 16'h0001; op_mask = 16'hFFFF;
      case (idx)
        0: begin
          op_base = 16'h0100; op_cnt = 5'd16;
          for (int k = 0; k < 16; k++) mem[16'h0100 + k] = 16'(k * 3);
        end
        1: begin
          op_st = 1'b1; op_base = 16'h0200; op_stride = 16'hFFFE; op_cnt = 5'd4;
          for (int k = 0; k < 4; k++) op_svec[k*16 +: 16] = 16'(16'hA0 + k);
        end
        2: begin op_base = 16'h0300; op_cnt = 5'd8; op_mask = 16'h00A5; end
        3: begin op_base = 16'hFFFF; op_cnt = 5'd2; end
        4: begin op_base = 16'h0350; op_cnt = 5'd0; end
        5: begin op_base = 16'h0400; op_stride = 16'd3; op_cnt = 5'd20; end
        6: begin op_base = 16'h0500; op_cnt = 5'd4; op_restart = 2; end
        default: begin
          op_st   = 1'($urandom);
          op_base = 16'($urandom);
          op_stride = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 6)) - 16'd3;
          op_cnt  = 5'($urandom_range(0, 20));
          op_mask = 16'($urandom);
          for (int k = 1; k < 64; k++) ready_plan[k] = ($urandom_range(0, 3) != 0);
        end
      endcase
      model_op();
      if (idx >= 7 && $urandom_range(0, 2) == 0) op_restart = $urandom_range(1, exp_done);
      run_op();

      total++;
      if (done_cyc !== exp_done) begin
        bad++;
        $display("FAIL op%0d done_cycle got=%0d required=%0d", idx, done_cyc, exp_done);
      end
      total++;
      if (done_cnt !== 1) begin
        bad++;
        $display("FAIL op%0d done_pulses got=%0d required=1", idx, done_cnt);
      end
      total++;
      if (last_busy !== 1'b0) begin
        bad++;
        $display("FAIL op%0d busy_after_done got=%b required=0", idx, last_busy);
      end
      total++;
      if (acc_cyc.size() != exp_cyc.size()) begin
        bad++;
        $display("FAIL op%0d access_count got=%0d required=%0d", idx, acc_cyc.size(), exp_cyc.size());
      end
      for (int k = 0; k < acc_cyc.size() && k < exp_cyc.size(); k++) begin
        total++;
        if (acc_cyc[k] !== exp_cyc[k] || acc_addr[k] !== exp_addr[k] ||
            acc_wr[k] !== exp_wr[k] || acc_data[k] !== exp_data[k]) begin
          bad++;
          $display("FAIL op%0d access%0d got cyc=%0d addr=%h wr=%b data=%h required cyc=%0d addr=%h wr=%b data=%h",
                   idx, k, acc_cyc[k], acc_addr[k], acc_wr[k], acc_data[k],
                   exp_cyc[k], exp_addr[k], exp_wr[k], exp_data[k]);
        end
      end
      total++;
      if (load_vec !== exp_vec) begin
        bad++;
        $display("FAIL op%0d load_vec got=%h required=%h", idx, load_vec, exp_vec);
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 64; k++) ready_plan[k] = 1'b1;
    ready_plan[2] = 1'b0; ready_plan[3] = 1'b0;
    op_st = 1'b0; op_base = 16'h0700; op_stride = 16'h0001; op_cnt = 5'd3;
    op_mask = 16'h0007; op_svec = '0; op_restart = -1;
    run_op();
    total++;
    if (done_cyc !== 7) begin
      bad++;
      $display("FAIL stall_done_cycle got=%0d required=7", done_cyc);
    end
    for (int c = 2; c <= 4; c++) begin
      total++;
      if (snap_rd[c] !== 1'b1 || snap_addr[c] !== 16'h0701) begin
        bad++;
        $display("FAIL stall_hold cyc%0d got RD=%b Addr=%h required RD=1 Addr=0701", c, snap_rd[c], snap_addr[c]);
      end
    end
    total++;
    if (load_vec[16 +: 16] !== mem[16'h0701] || load_vec[48 +: 208] !== '0) begin
      bad++;
      $display("FAIL stall_capture lane1 got=%h required=%h", load_vec[16 +: 16], mem[16'h0701]);
    end
  endtask

  task automatic test_abort();
    int n_acc;
    for (int k = 0; k < 64; k++) ready_plan[k] = 1'b1;
    clear_logs();
    cyc = 0;
    step();
    start = 1'b1; is_store = 1'b0; base_addr = 16'h0600; stride = 16'h0001;
    count = 5'd16; mask = 16'hFFFF; store_vec = '0;
    for (int c = 1; c <= 6; c++) begin
      cyc = c;
      step();
      start = 1'b0;
    end
    total++;
    if (RD !== 1'b1 || Addr !== 16'h0605) begin
      bad++;
      $display("FAIL abort_lane5_issue got RD=%b Addr=%h required RD=1 Addr=0605", RD, Addr);
    end
    Reset = 1'b1;
    cyc = 7;
    step();
    total++;
    if (RD !== 1'b0 || WR !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_vec !== '0) begin
      bad++;
      $display("FAIL abort_state got RD=%b WR=%b busy=%b done=%b lv_zero=%b required 0 0 0 0 1",
               RD, WR, busy, done, load_vec == '0);
    end
    Reset = 1'b0;
    n_acc = acc_cyc.size();
    for (int c = 8; c <= 12; c++) begin
      cyc = c;
      step();
    end
    total++;
    if (acc_cyc.size() != n_acc || done_cnt != 0) begin
      bad++;
      $display("FAIL abort_quiet accesses=%0d dones=%0d required accesses=%0d dones=0",
               acc_cyc.size(), done_cnt, n_acc);
    end
  endtask

  initial begin
    for (int k = 0; k < 65536; k++) mem[k] = 16'($urandom);
    for (int k = 0; k < 64; k++) ready_plan[k] = 1'b1;
    Reset = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0; stride = '0;
    count = '0; mask = '0; store_vec = '0; DataIn = '0; mem_ready = 1'b1;
    pend = 1'b0; done_cyc = -1; done_cnt = 0;
    test_reset();
    test_transfers();
    test_stall();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
